// File: rtl/int_to_fp.sv
// int_to_fp: iterative 8-bit two's-complement integer to 13-bit {sign, exp[3:0], mant[7:0]} float converter
module int_to_fp (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_int,
   input  logic        i_valid,
   output logic        o_ready,
   output logic [12:0] o_fp,
   output logic        o_valid
);
   typedef enum logic {IDLE, NORM} state_t;
   state_t      state_q, state_d;
   logic        sign_q, sign_d;
   logic [7:0]  mag_q, mag_d;
   logic [3:0]  exp_q, exp_d;
   logic [12:0] fp_q, fp_d;
   logic        valid_q, valid_d;
   assign o_ready = state_q == IDLE;
   assign o_fp    = fp_q;
   assign o_valid = valid_q;
   // next-state: capture in IDLE, then shift left until the mantissa MSB is set (or finish at once on zero)
   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      mag_d   = mag_q;
      exp_d   = exp_q;
      fp_d    = fp_q;
      valid_d = 1'b0;
      if (state_q == IDLE) begin
         if (i_valid) begin
            sign_d  = i_int[7];
            mag_d   = i_int[7] ? 8'(-i_int) : i_int;
            exp_d   = 4'd8;
            state_d = NORM;
         end
      end else if (mag_q == 8'd0) begin
         fp_d    = 13'd0;
         valid_d = 1'b1;
         state_d = IDLE;
      end else if (mag_q[7]) begin
         fp_d    = {sign_q, exp_q, mag_q};
         valid_d = 1'b1;
         state_d = IDLE;
      end else begin
         mag_d = mag_q << 1;
         exp_d = exp_q - 4'd1;
      end
   end
   // state registers with synchronous reset; a reset discards any conversion in flight
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         sign_q  <= 1'b0;
         mag_q   <= 8'd0;
         exp_q   <= 4'd0;
         fp_q    <= 13'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         mag_q   <= mag_d;
         exp_q   <= exp_d;
         fp_q    <= fp_d;
         valid_q <= valid_d;
      end
   end
endmodule
